// File: rtl/fmul_arb_pkg.sv
// ============================================================================
// Module   : fmul_arb_pkg
// Purpose  : Shared constants, tag type and clog2 helper for the shared
//            floating-point multiplier arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fmul_arb_pkg;

    localparam int FP_WIDTH = 32;
    localparam int FP_EXP   = 8;
    localparam int FP_MAT   = 23;

    // Widest requester ID needed for up to 16 requesters.
    localparam int MAX_IDW  = 4;

    typedef struct packed {
        logic               valid;
        logic [MAX_IDW-1:0] id;
    } tag_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational N-way round-robin selector; the first requester
//            at or above ptr wins, wrapping to index 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import fmul_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] idx,
    output logic           any
);

    int w_j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        w_j   = 0;
        for (int k = 0; k < N; k++) begin
            // Wrap at N, not at 2**IDW, so non-power-of-two N never aliases.
            w_j = int'(ptr) + k;
            if (w_j >= N) begin
                w_j = w_j - N;
            end
            if (!any && req[w_j]) begin
                any        = 1'b1;
                grant[w_j] = 1'b1;
                idx        = IDW'(w_j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fmul_share_arbiter.sv
// ============================================================================
// Module   : fmul_share_arbiter
// Purpose  : Round-robin time-sharing of one pipelined FP multiplier among N
//            requesters, with an owner-tag pipeline matched to MUL_LAT.
//            Optional macro FMUL_ARB_PERF_EN adds busy/grant counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fmul_share_arbiter
    import fmul_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int WIDTH     = FP_WIDTH,
    parameter int WIDTH_exp = FP_EXP,
    parameter int WIDTH_mat = FP_MAT,
    parameter int MUL_LAT   = 1,
    parameter int IDW       = clog2(N)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               hold,
    input  logic [N-1:0]       req_valid,
    output logic [N-1:0]       req_ready,
    input  logic [N*WIDTH-1:0] req_op1,
    input  logic [N*WIDTH-1:0] req_op2,
    input  logic [N-1:0]       req_exce,
    output logic [WIDTH-1:0]   mul_op1,
    output logic [WIDTH-1:0]   mul_op2,
    output logic               mul_exce_in,
    input  logic [WIDTH-1:0]   mul_result,
    input  logic               mul_exce_out,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic [WIDTH-1:0]   rsp_result,
    output logic               rsp_exce
`ifdef FMUL_ARB_PERF_EN
    ,
    output logic [31:0]        busy_cnt,
    output logic [N*16-1:0]    grant_cnt
`endif
);

    localparam bit c_fmt_ok = (1 + WIDTH_exp + WIDTH_mat == WIDTH);

    logic [N-1:0]   w_req;
    logic [N-1:0]   w_grant;
    logic [IDW-1:0] w_idx;
    logic           w_any;
    logic [IDW-1:0] w_ptr_next;
    logic [IDW-1:0] r_ptr;
    tag_t           r_launch;
    tag_t           r_tag [MUL_LAT];
    logic           w_unused_ok;

    assign w_req      = (hold || RST) ? '0 : req_valid;
    assign req_ready  = w_grant;
    assign w_ptr_next = (w_idx == IDW'(N - 1)) ? '0 : w_idx + IDW'(1);

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_rr_pick (
        .req   (w_req),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_idx),
        .any   (w_any)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ptr       <= '0;
            r_launch    <= '0;
            mul_op1     <= '0;
            mul_op2     <= '0;
            mul_exce_in <= 1'b0;
        end else begin
            r_launch.valid <= w_any;
            r_launch.id    <= MAX_IDW'(w_idx);
            if (w_any) begin
                r_ptr       <= w_ptr_next;
                mul_op1     <= req_op1[w_idx*WIDTH +: WIDTH];
                mul_op2     <= req_op2[w_idx*WIDTH +: WIDTH];
                mul_exce_in <= req_exce[w_idx];
            end
        end
    end

    // Shifts every cycle, independent of hold, so launched products drain.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= r_launch;
            for (int i = 1; i < MUL_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign rsp_valid   = r_tag[MUL_LAT-1].valid;
    assign rsp_id      = r_tag[MUL_LAT-1].id[IDW-1:0];
    assign rsp_result  = mul_result;
    assign rsp_exce    = mul_exce_out;
    assign w_unused_ok = &{1'b0, c_fmt_ok, r_tag[MUL_LAT-1].id};

`ifdef FMUL_ARB_PERF_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy_cnt <= '0;
        end else if (r_launch.valid && (busy_cnt != '1)) begin
            busy_cnt <= busy_cnt + 32'd1;
        end
    end

    generate
        for (genvar g = 0; g < N; g++) begin : g_grant_cnt
            logic [15:0] r_cnt;
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_cnt <= '0;
                end else if (w_grant[g] && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
            assign grant_cnt[g*16 +: 16] = r_cnt;
        end
    endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_fmul_share_arbiter.sv
// ============================================================================
// Module   : tb_fmul_share_arbiter
// Purpose  : Directed self-checking bench: N=4/MUL_LAT=1 and N=3/MUL_LAT=3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fmul_share_arbiter;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, hold;

    // ---------------- DUT A: N=4, MUL_LAT=1 ----------------
    logic [3:0]     req_valid, req_ready, req_exce;
    logic [4*W-1:0] req_op1, req_op2;
    logic [W-1:0]   mul_op1, mul_op2, mul_result, rsp_result;
    logic           mul_exce_in, mul_exce_out, rsp_valid, rsp_exce;
    logic [1:0]     rsp_id;

    // ---------------- DUT B: N=3, MUL_LAT=3 ----------------
    logic [2:0]     v3, r3, e3;
    logic [3*W-1:0] o13, o23;
    logic [W-1:0]   mo13, mo23, mr3, rr3;
    logic           mei3, meo3, rv3, re3;
    logic [1:0]     rid3;
    logic [W-1:0]   p3 [3];
    logic           pe3 [3];

`ifdef FMUL_ARB_PERF_EN
    logic [31:0]    busy_a, busy_b;
    logic [63:0]    gcnt_a;
    logic [47:0]    gcnt_b;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // Stand-in multiplier: one known FP product, otherwise a traceable sum.
    function automatic logic [W-1:0] fmul_stub(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == 32'h3FC00000 && b == 32'h3FE00000) return 32'h40280000;
        return a + b;
    endfunction

    always @(posedge clk) begin
        mul_result   <= fmul_stub(mul_op1, mul_op2);
        mul_exce_out <= mul_exce_in;
        p3[0]  <= fmul_stub(mo13, mo23);
        p3[1]  <= p3[0];
        p3[2]  <= p3[1];
        pe3[0] <= mei3;
        pe3[1] <= pe3[0];
        pe3[2] <= pe3[1];
    end
    assign mr3  = p3[2];
    assign meo3 = pe3[2];

    fmul_share_arbiter #(.N(4), .MUL_LAT(1)) u_dut (
        .CLK(clk), .RST(rst), .hold(hold),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2), .req_exce(req_exce),
        .mul_op1(mul_op1), .mul_op2(mul_op2), .mul_exce_in(mul_exce_in),
        .mul_result(mul_result), .mul_exce_out(mul_exce_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_exce(rsp_exce)
`ifdef FMUL_ARB_PERF_EN
        , .busy_cnt(busy_a), .grant_cnt(gcnt_a)
`endif
    );

    fmul_share_arbiter #(.N(3), .MUL_LAT(3)) u_dut3 (
        .CLK(clk), .RST(rst), .hold(hold),
        .req_valid(v3), .req_ready(r3),
        .req_op1(o13), .req_op2(o23), .req_exce(e3),
        .mul_op1(mo13), .mul_op2(mo23), .mul_exce_in(mei3),
        .mul_result(mr3), .mul_exce_out(meo3),
        .rsp_valid(rv3), .rsp_id(rid3),
        .rsp_result(rr3), .rsp_exce(re3)
`ifdef FMUL_ARB_PERF_EN
        , .busy_cnt(busy_b), .grant_cnt(gcnt_b)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Moves to 2 time units after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0;
        req_valid = '0; req_exce = '0; req_op1 = '0; req_op2 = '0;
        v3 = '0; e3 = '0; o13 = '0; o23 = '0;
        tick(); tick();

        // Reset state, including ready gated low by reset with requests valid.
        req_valid = 4'hF; #1;
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_op1", 64'(mul_op1), 64'h0);
        chk("rst_op2", 64'(mul_op2), 64'h0);
        chk("rst_exce_in", 64'(mul_exce_in), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_id", 64'(rsp_id), 64'h0);
        req_valid = '0; rst = 1'b0;
        tick();

        // Single request from requester 2.
        req_op1[2*W +: W] = 32'h3FC00000;
        req_op2[2*W +: W] = 32'h3FE00000;
        req_valid = 4'b0100; #1;
        chk("single_ready", 64'(req_ready), 64'h4);
        tick(); req_valid = '0; #1;
        chk("single_op1", 64'(mul_op1), 64'h3FC00000);
        chk("single_op2", 64'(mul_op2), 64'h3FE00000);
        chk("single_early", 64'(rsp_valid), 64'h0);
        tick();
        chk("single_valid", 64'(rsp_valid), 64'h1);
        chk("single_id", 64'(rsp_id), 64'h2);
        chk("single_result", 64'(rsp_result), 64'h40280000);
        tick();
        chk("single_done", 64'(rsp_valid), 64'h0);

        // All busy from reset: strict 0,1,2,3 rotation, responses 2 cycles later.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_op1[i*W +: W] = 32'(i + 1);
            req_op2[i*W +: W] = 32'h100;
        end
        req_valid = 4'hF; #1;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("busy_ready_%0d", c), 64'(req_ready), 64'(4'b1 << (c % 4)));
            if (c >= 2) begin
                chk($sformatf("busy_rsp_v_%0d", c), 64'(rsp_valid), 64'h1);
                chk($sformatf("busy_rsp_id_%0d", c), 64'(rsp_id), 64'((c - 2) % 4));
            end else begin
                chk($sformatf("busy_rsp_v_%0d", c), 64'(rsp_valid), 64'h0);
            end
            tick();
        end
        req_valid = '0; #1;
        chk("busy_tail_id2", 64'(rsp_id), 64'h2);
        chk("busy_tail_res2", 64'(rsp_result), 64'h103);
        tick();
        chk("busy_tail_v3", 64'(rsp_valid), 64'h1);
        chk("busy_tail_id3", 64'(rsp_id), 64'h3);
        chk("busy_tail_res3", 64'(rsp_result), 64'h104);
        tick();
        chk("busy_drained", 64'(rsp_valid), 64'h0);

        // Hold: in-flight product from requester 0 still returns on schedule.
        req_valid = 4'b0001; #1;
        chk("hold_pre_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = 4'b1010; hold = 1'b1; #1;
        chk("hold_ready_1", 64'(req_ready), 64'h0);
        tick();
        chk("hold_ready_2", 64'(req_ready), 64'h0);
        chk("hold_inflight_v", 64'(rsp_valid), 64'h1);
        chk("hold_inflight_id", 64'(rsp_id), 64'h0);
        for (int c = 3; c <= 5; c++) begin
            tick();
            chk($sformatf("hold_ready_%0d", c), 64'(req_ready), 64'h0);
            chk($sformatf("hold_rsp_%0d", c), 64'(rsp_valid), 64'h0);
        end
        hold = 1'b0; #1;
        chk("hold_rel_1", 64'(req_ready), 64'h2);
        tick(); req_valid = 4'b1000; #1;
        chk("hold_rel_3", 64'(req_ready), 64'h8);
        tick(); req_valid = '0; #1;
        chk("hold_rsp1_v", 64'(rsp_valid), 64'h1);
        chk("hold_rsp1_id", 64'(rsp_id), 64'h1);
        tick();
        chk("hold_rsp3_v", 64'(rsp_valid), 64'h1);
        chk("hold_rsp3_id", 64'(rsp_id), 64'h3);
        chk("hold_rsp3_res", 64'(rsp_result), 64'h104);

        // Exception passthrough on requester 0, then a clean one on requester 1.
        tick();
        req_valid = 4'b0001; req_exce = 4'b0001; #1;
        chk("exc_ready", 64'(req_ready), 64'h1);
        tick(); req_valid = 4'b0010; req_exce = 4'b0000; #1;
        chk("exc_launch", 64'(mul_exce_in), 64'h1);
        tick(); req_valid = '0; #1;
        chk("exc_rsp_v", 64'(rsp_valid), 64'h1);
        chk("exc_rsp_id", 64'(rsp_id), 64'h0);
        chk("exc_rsp_flag", 64'(rsp_exce), 64'h1);
        chk("exc_clear_launch", 64'(mul_exce_in), 64'h0);
        tick();
        chk("exc_clear_rsp", 64'(rsp_exce), 64'h0);
        chk("exc_clear_id", 64'(rsp_id), 64'h1);

        // Reset one cycle after a grant to requester 2 (ptr would be 3).
        tick();
        req_valid = 4'b0100; #1;
        chk("rmf_ready", 64'(req_ready), 64'h4);
        tick();
        req_valid = 4'b1010; rst = 1'b1; #1;
        chk("rmf_ready_rst", 64'(req_ready), 64'h0);
        chk("rmf_rsp_rst", 64'(rsp_valid), 64'h0);
        tick();
        chk("rmf_rsp_sched", 64'(rsp_valid), 64'h0);
        rst = 1'b0; #1;
        chk("rmf_ptr0_grant", 64'(req_ready), 64'h2);
        tick(); req_valid = '0; #1;
        chk("rmf_no_stale", 64'(rsp_valid), 64'h0);
        tick();
        chk("rmf_new_v", 64'(rsp_valid), 64'h1);
        chk("rmf_new_id", 64'(rsp_id), 64'h1);

        // N=3, MUL_LAT=3: wrap at 3, four-cycle latency.
        for (int i = 0; i < 3; i++) begin
            o13[i*W +: W] = 32'(i + 1);
            o23[i*W +: W] = 32'h200;
        end
        v3 = 3'b111; #1;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("n3_ready_%0d", c), 64'(r3), 64'(3'b1 << (c % 3)));
            if (c >= 4) begin
                chk($sformatf("n3_rsp_v_%0d", c), 64'(rv3), 64'h1);
                chk($sformatf("n3_rsp_id_%0d", c), 64'(rid3), 64'((c - 4) % 3));
            end else begin
                chk($sformatf("n3_rsp_v_%0d", c), 64'(rv3), 64'h0);
            end
            tick();
        end
        v3 = '0; #1;
        for (int c = 6; c < 10; c++) begin
            chk($sformatf("n3_tail_v_%0d", c), 64'(rv3), 64'h1);
            chk($sformatf("n3_tail_id_%0d", c), 64'(rid3), 64'((c - 4) % 3));
            chk($sformatf("n3_tail_res_%0d", c), 64'(rr3), 64'(32'h201 + 32'((c - 4) % 3)));
            tick();
        end
        chk("n3_drained", 64'(rv3), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
